mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the single-port unified instruction/data memory of the multi-cycle CPU. Port C is the CPU control path (fetch, load, store); port D is the program loader/debug port. The block serialises accesses, drives the memory port, times the fixed read latency and returns read data with a one-cycle valid pulse. It replaces the direct CPU-to-memory connection.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, memory read latency in cycles; legal values ≥ 1

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_c_req / i_d_req  in  1  access request, ports C / D
- i_c_we / i_d_we  in  1  1 = write, 0 = read
- i_c_addr / i_d_addr  in  AW  byte address
- i_c_wdata / i_d_wdata  in  DW  write data
- o_c_gnt / o_d_gnt  out  1  one-cycle pulse: access issued to memory
- o_c_rvalid / o_d_rvalid  out  1  one-cycle pulse: o_rdata holds that port's read result
- o_rdata  out  DW  registered read data, shared by both ports
- o_m_en, o_m_we  out  1  memory enable, write enable
- o_m_addr  out  AW  memory address
- o_m_wdata  out  DW  memory write data
- i_m_rdata  in  DW  memory read data, valid MEM_LAT cycles after the o_m_en cycle
- o_state  out  2  current FSM state, for debug

## Operation
- States:
  - IDLE=0: arbitrate; if any request, latch the winner's id, we, addr and wdata, go to ACCESS; else stay.
  - ACCESS=1: o_m_en=1, o_m_we/addr/wdata from the latch, winner's gnt=1. Write → IDLE. Read → WAIT.
  - WAIT=2: count MEM_LAT cycles, then capture i_m_rdata into o_rdata and go to RESP.
  - RESP=3: winner's rvalid=1 → IDLE.
- Arbitration is round-robin. A single requester wins. On simultaneous requests, the port not served last wins. The last-served pointer updates on entering ACCESS and resets to D, so C wins the first tie.
- Requesters hold req, we, addr and wdata stable until their gnt. Request signals are sampled only in IDLE. A deasserted request after the latch edge does not cancel the access.
- o_rdata holds its value until the next read capture; only the capture updates it.
- The memory-side outputs are zero in every state except ACCESS.

## Timing
- Reset values: state IDLE, all gnt/rvalid/o_m_* = 0, o_rdata = 0, pointer = D.
- A request in IDLE at cycle t gives ACCESS and gnt at t+1.
  - A write completes at t+1; the block is back in IDLE at t+2.
  - A read has WAIT for cycles t+2..t+1+MEM_LAT. i_m_rdata is captured at the end of cycle t+1+MEM_LAT. RESP/rvalid is at t+2+MEM_LAT; IDLE at t+3+MEM_LAT.
- Occupancy per access: write 2 cycles, read MEM_LAT+3 cycles. There is no pipelining and only one access is outstanding.
- Reset mid-access:
  - Outputs clear asynchronously; an ACCESS-cycle write is dropped if reset asserts before the clock edge.
  - The in-flight read gets no rvalid.
  - Requesters must reissue after reset.
- While the block is busy, the other port's request is held off, with no lost requests as long as the requester holds its request. It is evaluated in the next IDLE.

## Structure
- Package mem_arb_pkg:
  - state encoding IDLE/ACCESS/WAIT/RESP
  - port ids PORT_C=0, PORT_D=1
  - counter width $clog2(MEM_LAT+1)
- Sub-module rr_arb2: combinational 2-way round-robin picker (inputs req[1:0], last; outputs winner, any) plus the registered last-served pointer.

## Test plan
- Reset, then C read at addr 0x10 with memory returning 0xDEADBEEF, MEM_LAT=1 → o_c_gnt at t+1, o_m_addr=0x10, o_c_rvalid at t+3 with o_rdata=0xDEADBEEF; o_d_* stay 0.
- D write 0x20 ← 0x12345678 → one cycle with o_m_en=o_m_we=1 and matching address/data at t+1, o_d_gnt pulse, no rvalid, back in IDLE at t+2.
- C and D both request reads continuously for 4 accesses → grant order C, D, C, D; each rvalid goes only to its own port.
- MEM_LAT=3, C read issued while D requests → D's gnt only after C's RESP (C rvalid at t+5, D gnt at t+7).
- i_rst_n asserted during WAIT → outputs 0 immediately, no rvalid; after release, a C request gets gnt on the second cycle.
- C deasserts req in the cycle after the latch edge (during ACCESS) → access still completes, with gnt and rvalid delivered.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Requester ids; they double as bit positions in the request vector.
  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Width of the read-latency counter for a given memory latency.
  function automatic int lat_cnt_w(input int mem_lat);
    return $clog2(mem_lat + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker with its registered last-served pointer.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic       o_winner,
  output logic       o_any
);

  logic last_q;
  logic last_d;

  // Pick the only requester, or on a tie the port that was not served last.
  always_comb begin
    o_any    = |i_req;
    o_winner = PORT_C;
    if (i_req == 2'b11) begin
      o_winner = ~last_q;
    end else if (i_req[PORT_D]) begin
      o_winner = PORT_D;
    end
  end

  // Remember the winner whenever an access is actually launched.
  always_comb begin
    last_d = last_q;
    if (i_update && o_any) begin
      last_d = o_winner;
    end
  end

  // Pointer starts at D so C wins the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_q <= PORT_D;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises ports C and D onto the single-port memory, times the fixed read
// latency and returns read data with a one-cycle valid pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_c_req,
  input  logic          i_c_we,
  input  logic [AW-1:0] i_c_addr,
  input  logic [DW-1:0] i_c_wdata,
  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  output logic          o_c_gnt,
  output logic          o_d_gnt,
  output logic          o_c_rvalid,
  output logic          o_d_rvalid,
  output logic [DW-1:0] o_rdata,
  output logic          o_m_en,
  output logic          o_m_we,
  output logic [AW-1:0] o_m_addr,
  output logic [DW-1:0] o_m_wdata,
  input  logic [DW-1:0] i_m_rdata,
  output logic [1:0]    o_state
);

  localparam int               CNT_W    = lat_cnt_w(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_e           state_q, state_d;
  logic             win_q, win_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    rdata_q, rdata_d;

  logic arb_winner;
  logic arb_any;
  logic arb_update;

  rr_arb2 u_arb (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_req    ({i_d_req, i_c_req}),
    .i_update (arb_update),
    .o_winner (arb_winner),
    .o_any    (arb_any)
  );

  // Next-state logic: latch the winner in IDLE, then walk ACCESS/WAIT/RESP.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    arb_update = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          arb_update = 1'b1;
          win_d      = arb_winner;
          we_d       = (arb_winner == PORT_D) ? i_d_we    : i_c_we;
          addr_d     = (arb_winner == PORT_D) ? i_d_addr  : i_c_addr;
          wdata_d    = (arb_winner == PORT_D) ? i_d_wdata : i_c_wdata;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d   = '0;
        state_d = we_q ? IDLE : WAIT;
      end
      WAIT: begin
        // The memory data is valid on the last WAIT cycle only.
        if (cnt_q == CNT_LAST) begin
          rdata_d = i_m_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched request; everything clears on reset, dropping any access.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      win_q   <= PORT_C;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode from registered state so reset clears them immediately.
  always_comb begin
    o_m_en     = 1'b0;
    o_m_we     = 1'b0;
    o_m_addr   = '0;
    o_m_wdata  = '0;
    o_c_gnt    = 1'b0;
    o_d_gnt    = 1'b0;
    o_c_rvalid = 1'b0;
    o_d_rvalid = 1'b0;
    if (state_q == ACCESS) begin
      o_m_en    = 1'b1;
      o_m_we    = we_q;
      o_m_addr  = addr_q;
      o_m_wdata = wdata_q;
      o_c_gnt   = (win_q == PORT_C);
      o_d_gnt   = (win_q == PORT_D);
    end
    if (state_q == RESP) begin
      o_c_rvalid = (win_q == PORT_C);
      o_d_rvalid = (win_q == PORT_D);
    end
  end

  assign o_rdata = rdata_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  typedef struct packed {
    logic [1:0]  state;
    logic        c_gnt;
    logic        d_gnt;
    logic        c_rv;
    logic        d_rv;
    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] rdata;
  } out_t;

  typedef struct packed {
    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
  } in_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  in_t  in_s  [2];
  out_t out_s [2];
  int   cyc   = 0;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: a fixed scramble of the address (0x10 holds 0xDEADBEEF).
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return 32'hDEADBEEF ^ ((a - 32'h10) * 32'h9E3779B1);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? LAT0 : LAT1;
    logic        c_gnt, d_gnt, c_rv, d_rv, m_en, m_we;
    logic [31:0] m_addr, m_wdata, rdata, m_rdata;
    logic [1:0]  state;
    int          en_cyc  = -1000;
    logic [31:0] en_addr = '0;

    // Memory model: data is only valid exactly LAT cycles after the enable.
    always @(negedge clk) begin
      if (m_en && !m_we) begin
        en_cyc  <= cyc;
        en_addr <= m_addr;
      end
    end
    assign m_rdata = (cyc == en_cyc + LAT) ? mem_f(en_addr) : 32'hBAD0BAD0;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_c_req    (in_s[g].c_req),
      .i_c_we     (in_s[g].c_we),
      .i_c_addr   (in_s[g].c_addr),
      .i_c_wdata  (in_s[g].c_wdata),
      .i_d_req    (in_s[g].d_req),
      .i_d_we     (in_s[g].d_we),
      .i_d_addr   (in_s[g].d_addr),
      .i_d_wdata  (in_s[g].d_wdata),
      .o_c_gnt    (c_gnt),
      .o_d_gnt    (d_gnt),
      .o_c_rvalid (c_rv),
      .o_d_rvalid (d_rv),
      .o_rdata    (rdata),
      .o_m_en     (m_en),
      .o_m_we     (m_we),
      .o_m_addr   (m_addr),
      .o_m_wdata  (m_wdata),
      .i_m_rdata  (m_rdata),
      .o_state    (state)
    );

    assign out_s[g] = {state, c_gnt, d_gnt, c_rv, d_rv, m_en, m_we, m_addr, m_wdata, rdata};
  end

  function automatic string fmt(input out_t o);
    return $sformatf("st=%0d cg=%b dg=%b crv=%b drv=%b en=%b we=%b a=%h wd=%h rd=%h",
                     o.state, o.c_gnt, o.d_gnt, o.c_rv, o.d_rv, o.m_en, o.m_we,
                     o.m_addr, o.m_wdata, o.rdata);
  endfunction

  task automatic check(input string nm, input out_t act, input out_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {%s} want {%s}", nm, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic out_t ox(input logic [1:0] st, input logic [3:0] gr, input logic en,
                              input logic we, input logic [31:0] ma, input logic [31:0] mw,
                              input logic [31:0] rd);
    return {st, gr, en, we, ma, mw, rd};
  endfunction

  // Leaves the bench at a falling edge with reset just released (IDLE).
  task automatic do_reset();
    in_s[0] = '0;
    in_s[1] = '0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset lat1", out_s[0], '0);
    check("reset lat3", out_s[1], '0);
    rst_n = 1'b1;
  endtask

  // Random traffic against a transaction scheduler: each launched access
  // books its gnt/WAIT/RESP cycles and the next free IDLE cycle.
  task automatic run_random(input int k, input int lat, input int n);
    out_t        ev[];
    logic        rset[];
    logic [31:0] rval[];
    bit          pend[2];
    int          last;
    int          next_free;
    logic [31:0] run_rd;
    in_t         cur;
    out_t        e;
    ev   = new[n + lat + 8];
    rset = new[n + lat + 8];
    rval = new[n + lat + 8];
    foreach (ev[i]) begin
      ev[i]   = '0;
      rset[i] = 1'b0;
      rval[i] = '0;
    end
    do_reset();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    last = 1;
    next_free = 0;
    run_rd = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (rset[i]) run_rd = rval[i];
      e = ev[i];
      e.rdata = run_rd;
      check($sformatf("rand lat%0d cyc%0d", lat, i), out_s[k], e);
      if (ev[i].c_gnt) pend[0] = 1'b0;
      if (ev[i].d_gnt) pend[1] = 1'b0;
      cur = in_s[k];
      if (!pend[0]) begin
        pend[0]     = ($urandom_range(0, 9) < 5);
        cur.c_req   = pend[0];
        cur.c_we    = 1'($urandom_range(0, 1));
        cur.c_addr  = $urandom;
        cur.c_wdata = $urandom;
      end
      if (!pend[1]) begin
        pend[1]     = ($urandom_range(0, 9) < 5);
        cur.d_req   = pend[1];
        cur.d_we    = 1'($urandom_range(0, 1));
        cur.d_addr  = $urandom;
        cur.d_wdata = $urandom;
      end
      in_s[k] = cur;
      if (i >= next_free && (pend[0] || pend[1])) begin
        int g;
        int win;
        logic we;
        logic [31:0] a;
        logic [31:0] d;
        g = i + 1;
        if (pend[0] && pend[1]) win = (last == 1) ? 0 : 1;
        else win = pend[0] ? 0 : 1;
        last = win;
        we = (win == 1) ? cur.d_we    : cur.c_we;
        a  = (win == 1) ? cur.d_addr  : cur.c_addr;
        d  = (win == 1) ? cur.d_wdata : cur.c_wdata;
        ev[g].state   = 2'd1;
        ev[g].c_gnt   = (win == 0);
        ev[g].d_gnt   = (win == 1);
        ev[g].m_en    = 1'b1;
        ev[g].m_we    = we;
        ev[g].m_addr  = a;
        ev[g].m_wdata = d;
        if (we) begin
          next_free = i + 2;
        end else begin
          for (int j = 1; j <= lat; j++) ev[g + j].state = 2'd2;
          ev[g + lat + 1].state = 2'd3;
          ev[g + lat + 1].c_rv  = (win == 0);
          ev[g + lat + 1].d_rv  = (win == 1);
          rset[g + lat + 1]     = 1'b1;
          rval[g + lat + 1]     = mem_f(a);
          next_free = g + lat + 2;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    in_t  i_none, i_crd, i_dwr, i_both;
    logic [31:0] r0, rc, rd;
    logic [3:0]  g4;

    i_none = '0;
    i_crd  = {1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    i_dwr  = {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678};
    i_both = {1'b1, 1'b0, 32'h40, 32'hC0C0, 1'b1, 1'b0, 32'h80, 32'hD0D0};
    r0 = 32'hDEADBEEF;
    rc = mem_f(32'h40);
    rd = mem_f(32'h80);

    // Each row: inputs for one cycle, outputs expected in the following cycle.
    vecs.push_back({i_crd,  ox(2'd1, 4'b1000, 1, 0, 32'h10, 32'h0, 32'h0)});
    vecs.push_back({i_none, ox(2'd2, 4'b0000, 0, 0, 32'h0, 32'h0, 32'h0)});
    vecs.push_back({i_none, ox(2'd3, 4'b0010, 0, 0, 32'h0, 32'h0, r0)});
    vecs.push_back({i_none, ox(2'd0, 4'b0000, 0, 0, 32'h0, 32'h0, r0)});
    vecs.push_back({i_dwr,  ox(2'd1, 4'b0100, 1, 1, 32'h20, 32'h12345678, r0)});
    vecs.push_back({i_none, ox(2'd0, 4'b0000, 0, 0, 32'h0, 32'h0, r0)});
    vecs.push_back({i_none, ox(2'd0, 4'b0000, 0, 0, 32'h0, 32'h0, r0)});
    vecs.push_back({i_both, ox(2'd1, 4'b1000, 1, 0, 32'h40, 32'hC0C0, r0)});
    vecs.push_back({i_both, ox(2'd2, 4'b0000, 0, 0, 32'h0, 32'h0, r0)});
    vecs.push_back({i_both, ox(2'd3, 4'b0010, 0, 0, 32'h0, 32'h0, rc)});
    vecs.push_back({i_both, ox(2'd0, 4'b0000, 0, 0, 32'h0, 32'h0, rc)});
    vecs.push_back({i_both, ox(2'd1, 4'b0100, 1, 0, 32'h80, 32'hD0D0, rc)});
    vecs.push_back({i_both, ox(2'd2, 4'b0000, 0, 0, 32'h0, 32'h0, rc)});
    vecs.push_back({i_both, ox(2'd3, 4'b0001, 0, 0, 32'h0, 32'h0, rd)});
    vecs.push_back({i_both, ox(2'd0, 4'b0000, 0, 0, 32'h0, 32'h0, rd)});
    vecs.push_back({i_both, ox(2'd1, 4'b1000, 1, 0, 32'h40, 32'hC0C0, rd)});
    vecs.push_back({i_both, ox(2'd2, 4'b0000, 0, 0, 32'h0, 32'h0, rd)});
    vecs.push_back({i_both, ox(2'd3, 4'b0010, 0, 0, 32'h0, 32'h0, rc)});
    vecs.push_back({i_both, ox(2'd0, 4'b0000, 0, 0, 32'h0, 32'h0, rc)});
    vecs.push_back({i_both, ox(2'd1, 4'b0100, 1, 0, 32'h80, 32'hD0D0, rc)});
    vecs.push_back({i_none, ox(2'd2, 4'b0000, 0, 0, 32'h0, 32'h0, rc)});
    vecs.push_back({i_none, ox(2'd3, 4'b0001, 0, 0, 32'h0, 32'h0, rd)});
    vecs.push_back({i_none, ox(2'd0, 4'b0000, 0, 0, 32'h0, 32'h0, rd)});

    do_reset();
    foreach (vecs[i]) begin
      in_s[0] = vecs[i].in;
      @(negedge clk);
      check($sformatf("vec%0d", i), out_s[0], vecs[i].exp);
    end

    // MEM_LAT=3: C wins the first tie, D is held off until after C's RESP.
    do_reset();
    in_s[1] = {1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0};
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      g4 = {out_s[1].c_gnt, out_s[1].d_gnt, out_s[1].c_rv, out_s[1].d_rv};
      check_val($sformatf("holdoff t+%0d", j), {28'h0, g4},
                {28'h0, (j == 1), (j == 7), (j == 5), (j == 11)});
      if (j == 5)  check_val("holdoff c rdata", out_s[1].rdata, mem_f(32'h100));
      if (j == 11) check_val("holdoff d rdata", out_s[1].rdata, mem_f(32'h200));
      if (j == 1) in_s[1].c_req = 1'b0;
      if (j == 7) in_s[1].d_req = 1'b0;
    end

    // Reset asserted during WAIT: outputs clear at once and no rvalid follows.
    in_s[1] = {1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    @(negedge clk);
    check_val("rst seq gnt", {31'h0, out_s[1].c_gnt}, 32'h1);
    in_s[1].c_req = 1'b0;
    @(negedge clk);
    check_val("rst seq in WAIT", {30'h0, out_s[1].state}, 32'h2);
    rst_n = 1'b0;
    #1;
    check("rst async clear", out_s[1], '0);
    repeat (2) begin
      @(negedge clk);
      check("rst held", out_s[1], '0);
    end
    rst_n = 1'b1;
    in_s[1] = {1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    #1;
    check("rst release cycle", out_s[1], '0);
    @(negedge clk);
    check("rst second cycle gnt", out_s[1], ox(2'd1, 4'b1000, 1, 0, 32'h44, 32'h0, 32'h0));
    in_s[1].c_req = 1'b0;
    repeat (4) @(negedge clk);

    run_random(0, LAT0, 300);
    run_random(1, LAT1, 300);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
